// File: rtl/range_pkg.sv
// Shared types and defaults for the Collatz range sweeper.
package range_pkg;

  localparam int unsigned COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ADDR,
    CAP,
    EMIT,
    FIN
  } sweep_state_t;

endpackage

// File: rtl/range_sweeper.sv
// Host-side initiator for the Collatz range engine: launches one engine run, then streams back
// every stored (n, count) pair and tracks the largest count seen.
module range_sweeper #(
  parameter int unsigned RAM_WORDS     = 16,
  parameter int unsigned RAM_ADDR_BITS = 4,
  parameter int unsigned COUNT_W       = range_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_base,
  output logic               range_go,
  output logic [31:0]        range_start,
  input  logic               range_done,
  input  logic [COUNT_W-1:0] range_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_n,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_last,
  output logic               sweep_done,
  output logic [31:0]        max_n,
  output logic [COUNT_W-1:0] max_count
);
  import range_pkg::*;

  localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(RAM_WORDS - 1);

  sweep_state_t             state_q, state_d;
  logic [31:0]              base_q;
  logic [RAM_ADDR_BITS-1:0] index_q;
  logic                     req_ready_q;
  logic [31:0]              out_n_q;
  logic [COUNT_W-1:0]       out_count_q;
  logic                     out_last_q;
  logic [31:0]              max_n_q;
  logic [COUNT_W-1:0]       max_count_q;
  logic [31:0]              cur_n;

  assign cur_n     = base_q + 32'(index_q);
  assign req_ready = req_ready_q;
  assign out_n     = out_n_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;
  assign max_n     = max_n_q;
  assign max_count = max_count_q;

  always_comb begin
    state_d     = state_q;
    range_go    = 1'b0;
    range_start = 32'(index_q);
    out_valid   = 1'b0;
    sweep_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) state_d = LAUNCH;
      end
      LAUNCH: begin
        range_go    = 1'b1;
        range_start = base_q;
        state_d     = WAIT;
      end
      WAIT: begin
        if (range_done) state_d = ADDR;
      end
      ADDR: state_d = CAP;
      CAP:  state_d = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = out_last_q ? FIN : ADDR;
      end
      FIN: begin
        sweep_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is registered so it reads 0 while reset is held, rising the cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      base_q      <= '0;
      index_q     <= '0;
      out_n_q     <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      max_n_q     <= '0;
      max_count_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            base_q      <= req_base;
            index_q     <= '0;
            max_n_q     <= '0;
            max_count_q <= '0;
          end
        end
        CAP: begin
          out_count_q <= range_count;
          out_n_q     <= cur_n;
          out_last_q  <= (index_q == LastIdx);
          // Strict compare: ties keep the lowest index.
          if (range_count > max_count_q) begin
            max_count_q <= range_count;
            max_n_q     <= cur_n;
          end
        end
        EMIT: begin
          if (out_ready && !out_last_q) index_q <= index_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
